// File: rtl/ser_sched.sv
// ser_sched: round-robin scheduler that feeds NUM_REQ single-word holding slots
// into one shared serializer.
//
// Ports:
//   clk_i, rst_i    clock and asynchronous active-high reset
//   req_data_i      per-requester 16-bit word
//   req_mod_i       per-requester bit count (0 = 16 bits)
//   req_val_i       per-requester write strobe
//   req_ready_o     per-requester slot empty
//   ser_data_o      word presented to the serializer
//   ser_mod_o       bit count presented to the serializer
//   ser_val_o       one-cycle launch pulse
//   ser_busy_i      serializer busy flag
//   grant_id_o      requester owning the current or last transfer
//   busy_o          scheduler FSM not idle
//   drop_cnt_o      saturating count of discarded words (only with SER_SCHED_DROP_CNT_EN)
//
// Optional feature macro: SER_SCHED_DROP_CNT_EN adds the drop_cnt_o port.
module ser_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0][15:0]      req_data_i,
    input  logic [NUM_REQ-1:0][3:0]       req_mod_i,
    input  logic [NUM_REQ-1:0]            req_val_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [15:0]                   ser_data_o,
    output logic [3:0]                    ser_mod_o,
    output logic                          ser_val_o,
    input  logic                          ser_busy_i,
    output logic [ID_W-1:0]               grant_id_o,
    output logic                          busy_o
`ifdef SER_SCHED_DROP_CNT_EN
    ,
    output logic [7:0]                    drop_cnt_o
`endif
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned MOD_W  = 4;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [MOD_W-1:0]  mod;
    } slot_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LAUNCH     = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 ws_cnt_q, ws_cnt_d;
    logic [NUM_REQ-1:0]   full_q, full_d;
    slot_t                slot_q [NUM_REQ];
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ID_W-1:0]      winner;
    logic                 found;
    logic                 grant_c;
    logic [NUM_REQ-1:0]   acc_c;
    logic [NUM_REQ-1:0]   drop_mod_c;
    logic [NUM_REQ-1:0]   load_c;

    // Round-robin search for the first full slot starting at ptr_q
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
            if (!found && full_q[ID_W'(idx)]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_c) begin
            ptr_d = (int'(winner) == int'(NUM_REQ) - 1) ? '0 : winner + ID_W'(1);
        end
    end

    // Slot write acceptance; mod 1/2 words are accepted but never stored
    always_comb begin
        full_d = full_q;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            acc_c[i]      = req_val_i[i] && !full_q[i];
            drop_mod_c[i] = (req_mod_i[i] == 4'd1) || (req_mod_i[i] == 4'd2);
            load_c[i]     = acc_c[i] && !drop_mod_c[i];
            if (load_c[i]) full_d[i] = 1'b1;
        end
        if (grant_c) full_d[winner] = 1'b0;
    end

    // FSM next state
    always_comb begin
        state_d  = state_q;
        ws_cnt_d = ws_cnt_q;
        grant_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (found && !ser_busy_i) begin
                    grant_c = 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                ws_cnt_d = 1'b0;
                state_d  = WAIT_START;
            end
            WAIT_START: begin
                // Two cycles without busy means the serializer ignored the launch
                if (ser_busy_i)    state_d = WAIT_DONE;
                else if (ws_cnt_q) state_d = IDLE;
                else               ws_cnt_d = 1'b1;
            end
            WAIT_DONE: begin
                if (!ser_busy_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ws_cnt_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ws_cnt_q <= ws_cnt_d;
        end
    end

    // Slots, pointer and serializer-facing registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q      <= '0;
            req_ready_o <= '1;
            ptr_q       <= '0;
            ser_data_o  <= '0;
            ser_mod_o   <= '0;
            grant_id_o  <= '0;
            ser_val_o   <= 1'b0;
            busy_o      <= 1'b0;
            for (int i = 0; i < int'(NUM_REQ); i++) slot_q[i] <= '0;
        end else begin
            full_q      <= full_d;
            req_ready_o <= ~full_d;
            ptr_q       <= ptr_d;
            ser_val_o   <= (state_d == LAUNCH);
            busy_o      <= (state_d != IDLE);
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (load_c[i]) slot_q[i] <= '{data: req_data_i[i], mod: req_mod_i[i]};
            end
            if (grant_c) begin
                ser_data_o <= slot_q[winner].data;
                ser_mod_o  <= slot_q[winner].mod;
                grant_id_o <= winner;
            end
        end
    end

`ifdef SER_SCHED_DROP_CNT_EN
    logic [8:0] drop_sum_c;

    // Sum of this cycle's drops; 255 + NUM_REQ always fits in 9 bits
    always_comb begin
        drop_sum_c = 9'(drop_cnt_o);
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            drop_sum_c = drop_sum_c + 9'(acc_c[i] && drop_mod_c[i]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) drop_cnt_o <= '0;
        else       drop_cnt_o <= (drop_sum_c > 9'd255) ? 8'hFF : drop_sum_c[7:0];
    end
`endif

endmodule

// File: tb/tb_ser_sched.sv
// tb_ser_sched: scoreboard bench for ser_sched with a simple serializer model.
module tb_ser_sched;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] data;
        logic [3:0]  mod;
    } exp_t;

    logic              clk_i;
    logic              rst_i;
    logic [3:0][15:0]  req_data_i;
    logic [3:0][3:0]   req_mod_i;
    logic [3:0]        req_val_i;
    logic [3:0]        req_ready_o;
    logic [15:0]       ser_data_o;
    logic [3:0]        ser_mod_o;
    logic              ser_val_o;
    logic              ser_busy_i;
    logic [1:0]        grant_id_o;
    logic              busy_o;
`ifdef SER_SCHED_DROP_CNT_EN
    logic [7:0]        drop_cnt_o;
`endif

    ser_sched #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_data_i  (req_data_i),
        .req_mod_i   (req_mod_i),
        .req_val_i   (req_val_i),
        .req_ready_o (req_ready_o),
        .ser_data_o  (ser_data_o),
        .ser_mod_o   (ser_mod_o),
        .ser_val_o   (ser_val_o),
        .ser_busy_i  (ser_busy_i),
        .grant_id_o  (grant_id_o),
        .busy_o      (busy_o)
`ifdef SER_SCHED_DROP_CNT_EN
        ,
        .drop_cnt_o  (drop_cnt_o)
`endif
    );

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   n_launch  = 0;
    int   cyc       = 0;
    int   prev_launch_cyc = 0;
    int   last_launch_cyc = 0;
    int   ser_cnt   = 0;
    int   busy_len  = 16;
    bit   reject    = 1'b0;
    int   base;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serializer model plus launch monitor, both on the falling edge
    always @(negedge clk_i) begin
        exp_t e;
        cyc++;
        if (rst_i)                        ser_cnt = 0;
        else if (ser_val_o && !reject)    ser_cnt = busy_len;
        else if (ser_cnt > 0)             ser_cnt--;
        ser_busy_i = (ser_cnt != 0);
        if (!rst_i && ser_val_o) begin
            n_launch++;
            prev_launch_cyc = last_launch_cyc;
            last_launch_cyc = cyc;
            if (sb.size() == 0) begin
                check("spurious_val", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("grant_id", 32'(grant_id_o), 32'(e.id));
                check("ser_data", 32'(ser_data_o), 32'(e.data));
                check("ser_mod",  32'(ser_mod_o),  32'(e.mod));
            end
        end
    end

    task automatic stage(input logic [1:0] i, input logic [15:0] d, input logic [3:0] m);
        req_data_i[i] = d;
        req_mod_i[i]  = m;
        req_val_i[i]  = 1'b1;
    endtask

    task automatic push(input logic [1:0] i, input logic [15:0] d, input logic [3:0] m);
        exp_t e;
        e.id = i; e.data = d; e.mod = m;
        sb.push_back(e);
    endtask

    task automatic commit();
        @(negedge clk_i);
        req_val_i = '0;
    endtask

    task automatic do_reset();
        rst_i     = 1'b1;
        req_val_i = '0;
        reject    = 1'b0;
        busy_len  = 16;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        sb.delete();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((sb.size() != 0 || busy_o || ser_busy_i) && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        check("idle_timeout", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_launch(input int target, input int budget);
        int n = 0;
        while (n_launch < target && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        check("launch_timeout", 32'(n_launch >= target), 32'd1);
    endtask

    initial begin
        rst_i      = 1'b1;
        req_val_i  = '0;
        req_data_i = '0;
        req_mod_i  = '0;
        ser_busy_i = 1'b0;

        // Reset values
        repeat (2) @(negedge clk_i);
        check("rst_ready",  32'(req_ready_o), 32'hF);
        check("rst_val",    32'(ser_val_o),   32'd0);
        check("rst_data",   32'(ser_data_o),  32'd0);
        check("rst_mod",    32'(ser_mod_o),   32'd0);
        check("rst_grant",  32'(grant_id_o),  32'd0);
        check("rst_busy",   32'(busy_o),      32'd0);

        // Single write, minimum latency
        do_reset();
        base = n_launch;
        @(negedge clk_i);
        stage(2'd2, 16'hA5C3, 4'd0);
        push(2'd2, 16'hA5C3, 4'd0);
        commit();
        check("lat_n1_val",   32'(ser_val_o),      32'd0);
        check("lat_n1_ready", 32'(req_ready_o[2]), 32'd0);
        @(negedge clk_i);
        check("lat_n2_val",   32'(ser_val_o),      32'd1);
        check("lat_n2_ready", 32'(req_ready_o[2]), 32'd1);
        wait_idle(100);
        check("single_count", 32'(n_launch - base), 32'd1);

        // All four slots at once, slot 0 rewritten during its own transfer
        do_reset();
        base = n_launch;
        @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            stage(2'(i), 16'h1000 + 16'(i), (i == 3) ? 4'd0 : 4'(i + 3));
            push(2'(i), 16'h1000 + 16'(i), (i == 3) ? 4'd0 : 4'(i + 3));
        end
        commit();
        wait_launch(base + 1, 20);
        @(negedge clk_i);
        check("rewrite_ready", 32'(req_ready_o[0]), 32'd1);
        stage(2'd0, 16'hBEEF, 4'd7);
        push(2'd0, 16'hBEEF, 4'd7);
        commit();
        wait_idle(400);
        check("rr_count", 32'(n_launch - base), 32'd5);
        check("rr_busy_end", 32'(busy_o), 32'd0);

        // Drops: mod 1/2 words never launch
        do_reset();
        base = n_launch;
        @(negedge clk_i);
        stage(2'd1, 16'h1234, 4'd2);
        commit();
        repeat (6) @(negedge clk_i);
        check("drop_no_launch", 32'(n_launch - base), 32'd0);
        check("drop_ready",     32'(req_ready_o[1]),  32'd1);
        check("drop_busy",      32'(busy_o),          32'd0);
`ifdef SER_SCHED_DROP_CNT_EN
        check("drop_cnt_1",     32'(drop_cnt_o),      32'd1);
`endif
        @(negedge clk_i);
        stage(2'd0, 16'h1111, 4'd1);
        stage(2'd3, 16'h3333, 4'd2);
        stage(2'd2, 16'h5555, 4'd0);
        push(2'd2, 16'h5555, 4'd0);
        commit();
        wait_idle(100);
        check("drop_mix_count", 32'(n_launch - base), 32'd1);
`ifdef SER_SCHED_DROP_CNT_EN
        check("drop_cnt_3",     32'(drop_cnt_o),      32'd3);
`endif

        // Serializer never goes busy: WAIT_START times out after 2 cycles
        do_reset();
        reject = 1'b1;
        base = n_launch;
        @(negedge clk_i);
        stage(2'd0, 16'h0A0A, 4'd0);
        stage(2'd1, 16'h0B0B, 4'd9);
        push(2'd0, 16'h0A0A, 4'd0);
        push(2'd1, 16'h0B0B, 4'd9);
        commit();
        wait_idle(100);
        check("rej_count", 32'(n_launch - base), 32'd2);
        check("rej_gap",   32'(last_launch_cyc - prev_launch_cyc), 32'd4);

        // Reset during WAIT_DONE with slots 1 and 3 still full
        do_reset();
        busy_len = 40;
        base = n_launch;
        @(negedge clk_i);
        stage(2'd2, 16'hC0DE, 4'd5);
        push(2'd2, 16'hC0DE, 4'd5);
        commit();
        wait_launch(base + 1, 20);
        @(negedge clk_i);
        stage(2'd1, 16'h0111, 4'd0);
        stage(2'd3, 16'h0333, 4'd0);
        commit();
        repeat (3) @(negedge clk_i);
        check("wd_busy",  32'(busy_o),      32'd1);
        check("wd_ready", 32'(req_ready_o), 32'h5);
        rst_i = 1'b1;
        #1;
        check("arst_ready", 32'(req_ready_o), 32'hF);
        check("arst_val",   32'(ser_val_o),   32'd0);
        check("arst_data",  32'(ser_data_o),  32'd0);
        check("arst_mod",   32'(ser_mod_o),   32'd0);
        check("arst_grant", 32'(grant_id_o),  32'd0);
        check("arst_busy",  32'(busy_o),      32'd0);
        repeat (2) @(negedge clk_i);
        rst_i    = 1'b0;
        busy_len = 16;
        repeat (10) @(negedge clk_i);
        check("arst_no_launch", 32'(n_launch - base), 32'd1);
        @(negedge clk_i);
        stage(2'd3, 16'h7E57, 4'd0);
        push(2'd3, 16'h7E57, 4'd0);
        commit();
        wait_idle(100);
        check("arst_new_count", 32'(n_launch - base), 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ser_sched.md
SER_SCHED -- requirements
Module: ser_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one serializer (2..8).
REQ-002 Parameter ID_W, default $clog2(NUM_REQ), width of grant_id_o.
REQ-003 clk_i  input  1  single clock; all logic on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 req_data_i  input  NUM_REQ x 16  per-requester parallel word.
REQ-006 req_mod_i  input  NUM_REQ x 4  per-requester bit count (0 = 16 bits).
REQ-007 req_val_i  input  NUM_REQ  per-requester write strobe.
REQ-008 req_ready_o  output  NUM_REQ  requester slot empty; a write is accepted only when ready is high.
REQ-009 ser_data_o  output  16  word driven to serializer data_i.
REQ-010 ser_mod_o  output  4  driven to serializer data_mod_i.
REQ-011 ser_val_o  output  1  one-cycle launch pulse to serializer data_val_i.
REQ-012 ser_busy_i  input  1  serializer busy_o.
REQ-013 grant_id_o  output  ID_W  index of the requester owning the current or last transfer.
REQ-014 busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 Each requester has one 21-bit holding slot (data, mod, full); req_ready_o[i] = !full[i], registered.
REQ-016 Write accepted on an edge with req_val_i[i] && req_ready_o[i]; full[i] set on that edge; req_ready_o[i] low from the next cycle.
REQ-017 A write to a slot holding mod 1 or mod 2 is accepted and immediately discarded (full stays 0); this is counted as a drop.
REQ-018 FSM states: IDLE, LAUNCH, WAIT_START, WAIT_DONE.
REQ-019 IDLE -> LAUNCH when any full[i] and ser_busy_i low; winner chosen round-robin starting at index (last grant + 1) mod NUM_REQ.
REQ-020 On the IDLE->LAUNCH edge: ser_data_o/ser_mod_o load the winner's slot, grant_id_o loads winner, full[winner] cleared, pointer updated.
REQ-021 LAUNCH: ser_val_o high for exactly this one cycle; next state WAIT_START.
REQ-022 WAIT_START: go WAIT_DONE when ser_busy_i high; if ser_busy_i still low after 2 cycles, go IDLE (serializer rejected launch).
REQ-023 WAIT_DONE -> IDLE on first cycle ser_busy_i low.
REQ-024 ser_data_o, ser_mod_o, grant_id_o hold their values from LAUNCH until the next grant.
REQ-025 Minimum latency: slot written at edge N -> ser_val_o high cycle N+2 (IDLE arbitration at N+1, LAUNCH at N+2).
REQ-026 A slot freed at grant may be rewritten from the following cycle, concurrently with its own transfer.
REQ-027 Simultaneous writes to several empty slots are all accepted in the same cycle.
REQ-028 With all slots permanently full, grants cycle 0,1,..,NUM_REQ-1,0 with no requester served twice before others.

Reset
REQ-029 While rst_i high: FSM IDLE, all full = 0, req_ready_o all 1, ser_val_o 0, ser_data_o 0, ser_mod_o 0, grant_id_o 0, pointer such that first grant search starts at index 0, busy_o 0.
REQ-030 Reset asserted mid-transfer aborts immediately; held words are lost; serializer reset is handled by its own srst_i.

Configuration
REQ-031 Macro SER_SCHED_DROP_CNT_EN: when defined, adds output drop_cnt_o (8 bits), incremented per REQ-017 drop, saturating at 255, cleared by rst_i; multiple drops in one cycle add their count, saturating.
REQ-032 Without SER_SCHED_DROP_CNT_EN: port drop_cnt_o absent, drop logic still discards mod 1/2 words.

Verification
REQ-033 Reset, then write req 2 data 16'hA5C3 mod 0 -> ser_val_o pulse 2 cycles later, ser_data_o A5C3, ser_mod_o 0, grant_id_o 2, req_ready_o[2] high next cycle.
REQ-034 All 4 slots written same cycle, serializer model busy 16 cycles each -> grants 0,1,2,3 in order, one ser_val_o per transfer, busy_o low only after the 4th.
REQ-035 Write req 1 mod 2 -> no ser_val_o, req_ready_o[1] stays high, drop_cnt_o 1 with macro defined.
REQ-036 Serializer model never asserts busy -> FSM returns to IDLE after 2 WAIT_START cycles, next full slot granted.
REQ-037 Assert rst_i during WAIT_DONE with slots 1,3 full -> all outputs at reset values same cycle, no ser_val_o after release until new writes.
